stack_calc: RTL and testbench
=============================

STACK_CALC -- requirements
Module: stack_calc

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Port clock  input  1  system clock; all state changes on rising edge.
REQ-003 Port reset  input  1  synchronous, active-low; 0 on a rising edge resets the block.
REQ-004 Port in_valid  input  1  one-cycle strobe; in_data carries a token.
REQ-005 Port in_data  input  32  token: bit31=0 is an unsigned operand (value in bits 30:0); bit31=1 is an operator with code in bits 3:0.
REQ-006 Port calc_ready  output  1  one-cycle pulse; accepted token fully processed.
REQ-007 Port is_equal  output  1  high from the '=' completion pulse until reset.
REQ-008 Port calc_answer  output  32  final result; valid while is_equal=1.
REQ-009 Port error  output  1  sticky fault flag.
REQ-010 Parameter DEPTH  default 8  entries in each of the operand stack and the operator stack.
REQ-011 Operator codes SHALL be 4'hA '+', 4'hB '-', 4'hC '*', 4'hD '/', 4'hE '='; all other codes are invalid.

Function
REQ-012 Evaluation SHALL be infix with precedence: '*' and '/' above '+' and '-'; equal precedence is left-associative.
REQ-013 States SHALL be IDLE, PUSH_NUM, REDUCE, PUSH_OP, FINISH, DONE.
REQ-014 IDLE: in_valid with an operand token goes to PUSH_NUM; with a valid non-'=' operator goes to REDUCE; with '=' goes to FINISH.
REQ-015 PUSH_NUM: push the operand, pulse calc_ready, return to IDLE; latency is accept edge T to calc_ready at T+1.
REQ-016 REDUCE: while the operator stack is non-empty and prec(top) >= prec(new), pop one operator and two operands, then push the result; one reduction per cycle.
REQ-017 REDUCE SHALL go to PUSH_OP when no reduction applies; PUSH_OP pushes the new operator, pulses calc_ready and returns to IDLE; calc_ready is at T+1+k for k reductions.
REQ-018 FINISH: reduce one operator per cycle until the operator stack is empty.
REQ-019 FINISH then loads calc_answer from the top of the operand stack (0 if empty), pulses calc_ready, sets is_equal and goes to DONE.
REQ-020 DONE: all in_valid SHALL be ignored; outputs hold until reset.
REQ-021 Arithmetic SHALL be 32-bit unsigned: '+' and '-' wrap modulo 2^32, '*' keeps the low 32 bits, '/' truncates.
REQ-022 Operand order: left = deeper stack entry; result = left op right.
REQ-023 Divide by zero SHALL produce result 0 and set error.
REQ-024 Invalid operator code: set error, change neither stack, pulse calc_ready at T+1.
REQ-025 Push onto a full stack (DEPTH entries): drop the token, set error, still pulse calc_ready.
REQ-026 Reduction with fewer than two operands: pop the operator, push 0, set error.
REQ-027 in_valid outside IDLE SHALL be ignored (no queuing); the upstream sender waits for calc_ready.
REQ-028 calc_ready SHALL never be high on two consecutive cycles.

Reset
REQ-029 reset=0 on any edge, including mid-REDUCE or FINISH, SHALL next cycle give state IDLE, both stacks empty, calc_ready=0, is_equal=0, calc_answer=0, error=0.
REQ-030 A token presented in the same cycle as reset=0 SHALL be discarded.

Verification
REQ-031 Tokens 2,'+',3,'=' -> calc_answer=5, is_equal=1, error=0; four calc_ready pulses.
REQ-032 Tokens 2,'+',3,'*',4,'=' -> calc_answer=14; the '*' token gets calc_ready at T+1 (k=0).
REQ-033 Tokens 10,'-',4,'-',3,'=' -> calc_answer=3; the second '-' gets calc_ready at T+2 (k=1).
REQ-034 Tokens 7,'/',0,'=' -> calc_answer=0, error=1; tokens 0,'-',1,'=' -> calc_answer=32'hFFFFFFFF.
REQ-035 Tokens 1,'+',2,'*',3 then '=' with reset=0 asserted during FINISH -> all outputs 0 next cycle; a new sequence 5,'=' then yields 5.
REQ-036 Nine operand tokens with no operator between them -> ninth token dropped, error=1, calc_ready pulses for all nine.

Source files
------------

// File: rtl/stack_calc.sv
// rtl/stack_calc.sv - infix integer calculator with operand/operator stacks
// Tokens arrive one at a time; '*' and '/' bind tighter than '+' and '-'.
module stack_calc #(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        calc_ready,
  output logic        is_equal,
  output logic [31:0] calc_answer,
  output logic        error
);

  localparam int AW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] FULL = AW'(DEPTH);
  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] TWO  = AW'(2);

  typedef enum logic [2:0] {IDLE, PUSH_NUM, REDUCE, PUSH_OP, FINISH, DONE} state_t;

  state_t        state;
  logic [31:0]   num_stk [DEPTH];
  logic [3:0]    op_stk  [DEPTH];
  logic [AW-1:0] num_sp;
  logic [AW-1:0] op_sp;
  logic [31:0]   tok_num;
  logic [3:0]    tok_op;
  logic          tok_skip;

  logic [IW-1:0] num_top_i, num_2nd_i, num_push_i, op_top_i, op_2nd_i, op_push_i, red_idx;
  logic [3:0]    new_op;
  logic          op_valid, need_reduce, more_reduce, reducing, red_err, short_stack;
  logic [31:0]   lhs, rhs, red_val;

  function automatic logic prec(input logic [3:0] code);
    return (code == 4'hC) || (code == 4'hD);
  endfunction

  assign num_top_i  = IW'(num_sp - ONE);
  assign num_2nd_i  = IW'(num_sp - TWO);
  assign num_push_i = IW'(num_sp);
  assign op_top_i   = IW'(op_sp - ONE);
  assign op_2nd_i   = IW'(op_sp - TWO);
  assign op_push_i  = IW'(op_sp);

  always_comb begin
    new_op      = in_data[3:0];
    op_valid    = (new_op >= 4'hA) && (new_op <= 4'hD);
    need_reduce = (op_sp != '0) && (prec(op_stk[op_top_i]) >= prec(new_op));
    // Looks one entry below the top, since the top is being popped this cycle.
    more_reduce = (op_sp >= TWO) && (prec(op_stk[op_2nd_i]) >= prec(tok_op));
    reducing    = (state == REDUCE) || ((state == FINISH) && (op_sp != '0));
    short_stack = (num_sp < TWO);
    lhs         = num_stk[num_2nd_i];
    rhs         = num_stk[num_top_i];
    red_err     = 1'b0;
    red_val     = '0;
    case (op_stk[op_top_i])
      4'hA:    red_val = lhs + rhs;
      4'hB:    red_val = lhs - rhs;
      4'hC:    red_val = lhs * rhs;
      4'hD: begin
        if (rhs == '0) red_err = 1'b1;
        else           red_val = lhs / rhs;
      end
      default: red_val = '0;
    endcase
    // Too few operands: whatever is there is consumed and a single 0 replaces it.
    if (short_stack) begin
      red_val = '0;
      red_err = 1'b1;
    end
    red_idx = short_stack ? '0 : num_2nd_i;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      num_sp      <= '0;
      op_sp       <= '0;
      tok_num     <= '0;
      tok_op      <= '0;
      tok_skip    <= 1'b0;
      calc_ready  <= 1'b0;
      is_equal    <= 1'b0;
      calc_answer <= '0;
      error       <= 1'b0;
    end else begin
      calc_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!in_data[31]) begin
              tok_num <= {1'b0, in_data[30:0]};
              state   <= PUSH_NUM;
            end else if (new_op == 4'hE) begin
              state <= FINISH;
            end else if (op_valid) begin
              tok_op   <= new_op;
              tok_skip <= 1'b0;
              state    <= need_reduce ? REDUCE : PUSH_OP;
            end else begin
              error    <= 1'b1;
              tok_skip <= 1'b1;
              state    <= PUSH_OP;
            end
          end
        end
        PUSH_NUM: begin
          if (num_sp == FULL) begin
            error <= 1'b1;
          end else begin
            num_stk[num_push_i] <= tok_num;
            num_sp              <= num_sp + ONE;
          end
          calc_ready <= 1'b1;
          state      <= IDLE;
        end
        REDUCE: begin
          if (!more_reduce) state <= PUSH_OP;
        end
        PUSH_OP: begin
          if (!tok_skip) begin
            if (op_sp == FULL) begin
              error <= 1'b1;
            end else begin
              op_stk[op_push_i] <= tok_op;
              op_sp             <= op_sp + ONE;
            end
          end
          calc_ready <= 1'b1;
          state      <= IDLE;
        end
        FINISH: begin
          if (op_sp == '0) begin
            calc_answer <= (num_sp == '0) ? '0 : num_stk[num_top_i];
            calc_ready  <= 1'b1;
            is_equal    <= 1'b1;
            state       <= DONE;
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase

      if (reducing) begin
        num_stk[red_idx] <= red_val;
        num_sp           <= short_stack ? ONE : num_sp - ONE;
        op_sp            <= op_sp - ONE;
        if (red_err) error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stack_calc.sv
// tb/tb_stack_calc.sv - table, directed and randomized checks for stack_calc
module tb_stack_calc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        calc_ready, is_equal, error;
  logic [31:0] calc_answer;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADD = 32'h8000000A;
  localparam logic [31:0] SUB = 32'h8000000B;
  localparam logic [31:0] MUL = 32'h8000000C;
  localparam logic [31:0] DIV = 32'h8000000D;
  localparam logic [31:0] EQ  = 32'h8000000E;
  localparam logic [31:0] BAD = 32'h80000005;
  localparam int NO_PULSE = 40;

  stack_calc #(.DEPTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .calc_ready  (calc_ready),
    .is_equal    (is_equal),
    .calc_answer (calc_answer),
    .error       (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          n;
    logic [31:0] tok [8];
    int          lat [8];
    logic [31:0] ans;
    logic        err;
  } vec_t;

  vec_t vecs [9];

  // Reference model: textbook two-stack infix evaluation on queues.
  logic [31:0] m_num [$];
  logic [3:0]  m_op  [$];
  logic        m_err;
  logic [31:0] m_ans;

  function automatic int prec(input logic [3:0] c);
    return (c == 4'hC || c == 4'hD) ? 1 : 0;
  endfunction

  function automatic void m_clear();
    m_num.delete();
    m_op.delete();
    m_err = 1'b0;
    m_ans = '0;
  endfunction

  function automatic void m_reduce();
    logic [3:0]  o;
    logic [31:0] a, b, r;
    o = m_op.pop_back();
    if (m_num.size() < 2) begin
      m_num.delete();
      m_num.push_back(32'd0);
      m_err = 1'b1;
      return;
    end
    b = m_num.pop_back();
    a = m_num.pop_back();
    case (o)
      4'hA: r = a + b;
      4'hB: r = a - b;
      4'hC: r = a * b;
      default: begin
        if (b == 0) begin r = 0; m_err = 1'b1; end
        else r = a / b;
      end
    endcase
    m_num.push_back(r);
  endfunction

  // Applies one token to the model; returns the expected calc_ready latency.
  function automatic int m_token(input logic [31:0] tok);
    logic [3:0] c;
    int k;
    if (!tok[31]) begin
      if (m_num.size() == 8) m_err = 1'b1;
      else m_num.push_back({1'b0, tok[30:0]});
      return 1;
    end
    c = tok[3:0];
    if (c == 4'hE) begin
      k = m_op.size();
      while (m_op.size() > 0) m_reduce();
      m_ans = (m_num.size() == 0) ? 32'd0 : m_num[$];
      return k + 1;
    end
    if (c < 4'hA || c > 4'hD) begin
      m_err = 1'b1;
      return 1;
    end
    k = 0;
    while (m_op.size() > 0 && prec(m_op[$]) >= prec(c)) begin
      m_reduce();
      k++;
    end
    if (m_op.size() == 8) m_err = 1'b1;
    else m_op.push_back(c);
    return 1 + k;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    m_clear();
  endtask

  // Presents one token; lat counts cycles from the accept edge to calc_ready.
  task automatic send(input logic [31:0] tok, output int lat);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = tok;
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = '0;
    lat = 0;
    while (!calc_ready && lat < NO_PULSE) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, " calc_ready"}, 32'(calc_ready), 32'd0);
    chk({name, " is_equal"}, 32'(is_equal), 32'd0);
    chk({name, " calc_answer"}, calc_answer, 32'd0);
    chk({name, " error"}, 32'(error), 32'd0);
  endtask

  initial begin
    int lat, n, r, exp_lat;
    logic [31:0] tok, rnd;
    logic [31:0] seq [12];
    logic [31:0] held;

    vecs[0] = '{4, '{32'd2, ADD, 32'd3, EQ, 0, 0, 0, 0}, '{1, 1, 1, 2, 0, 0, 0, 0}, 32'd5, 1'b0};
    vecs[1] = '{6, '{32'd2, ADD, 32'd3, MUL, 32'd4, EQ, 0, 0}, '{1, 1, 1, 1, 1, 3, 0, 0}, 32'd14, 1'b0};
    vecs[2] = '{6, '{32'd10, SUB, 32'd4, SUB, 32'd3, EQ, 0, 0}, '{1, 1, 1, 2, 1, 2, 0, 0}, 32'd3, 1'b0};
    vecs[3] = '{4, '{32'd7, DIV, 32'd0, EQ, 0, 0, 0, 0}, '{1, 1, 1, 2, 0, 0, 0, 0}, 32'd0, 1'b1};
    vecs[4] = '{4, '{32'd0, SUB, 32'd1, EQ, 0, 0, 0, 0}, '{1, 1, 1, 2, 0, 0, 0, 0}, 32'hFFFFFFFF, 1'b0};
    vecs[5] = '{5, '{32'd6, BAD, ADD, 32'd1, EQ, 0, 0, 0}, '{1, 1, 1, 1, 2, 0, 0, 0}, 32'd7, 1'b1};
    vecs[6] = '{1, '{EQ, 0, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 0}, 32'd0, 1'b0};
    vecs[7] = '{8, '{32'd3, MUL, 32'd4, SUB, 32'd2, MUL, 32'd5, EQ}, '{1, 1, 1, 2, 1, 1, 1, 3}, 32'd2, 1'b0};
    vecs[8] = '{3, '{ADD, 32'd5, EQ, 0, 0, 0, 0, 0}, '{1, 1, 2, 0, 0, 0, 0, 0}, 32'd0, 1'b1};

    repeat (2) @(negedge clock);
    reset = 1'b1;
    chk_zero("reset");

    for (int v = 0; v < 9; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].tok[i], lat);
        chk($sformatf("vec%0d tok%0d latency", v, i), 32'(lat), 32'(vecs[v].lat[i]));
      end
      chk($sformatf("vec%0d answer", v), calc_answer, vecs[v].ans);
      chk($sformatf("vec%0d is_equal", v), 32'(is_equal), 32'd1);
      chk($sformatf("vec%0d error", v), 32'(error), 32'(vecs[v].err));
      @(negedge clock);
      chk($sformatf("vec%0d single pulse", v), 32'(calc_ready), 32'd0);
    end

    // Tokens after '=' are ignored and outputs hold.
    held = calc_answer;
    send(32'd99, lat);
    chk("done ignores token", 32'(lat), 32'(NO_PULSE));
    chk("done holds answer", calc_answer, held);

    // Reset asserted while FINISH is still reducing.
    do_reset();
    foreach (vecs[1].tok[i]) if (i < 5) begin
      tok = (i == 3) ? MUL : vecs[1].tok[i];
      tok = (i == 0) ? 32'd1 : (i == 2) ? 32'd2 : (i == 4) ? 32'd3 : tok;
      send(tok, lat);
    end
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = EQ;
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clock);
    chk_zero("reset in finish");
    reset = 1'b1;
    m_clear();
    send(32'd5, lat);
    chk("after reset push latency", 32'(lat), 32'd1);
    send(EQ, lat);
    chk("after reset eq latency", 32'(lat), 32'd1);
    chk("after reset answer", calc_answer, 32'd5);
    chk("after reset error", 32'(error), 32'd0);

    // A token that coincides with reset is discarded.
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'd9;
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b0;
    send(EQ, lat);
    chk("reset token dropped", calc_answer, 32'd0);

    // Nine operands overflow the eight-entry operand stack.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      send(32'(i), lat);
      chk($sformatf("overflow tok%0d latency", i), 32'(lat), 32'd1);
      if (i >= 8) chk($sformatf("overflow tok%0d error", i), 32'(error), (i == 9) ? 32'd1 : 32'd0);
    end
    send(EQ, lat);
    chk("overflow answer", calc_answer, 32'd8);

    // Random expressions against the reference model.
    for (int s = 0; s < 30; s++) begin
      do_reset();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n - 1; i++) begin
        r = $urandom_range(0, 10);
        rnd = $urandom();
        if (r == 0)      seq[i] = 32'd0;
        else if (r == 1) seq[i] = {1'b0, rnd[30:0]};
        else if (r <= 4) seq[i] = 32'($urandom_range(1, 20));
        else if (r <= 8) seq[i] = 32'h80000000 | 32'(10 + r - 5);
        else if (r == 9) seq[i] = (rnd[3:0] == 4'hE) ? 32'h8000000F : {28'h8000000, rnd[3:0]};
        else             seq[i] = 32'($urandom_range(1, 5));
      end
      seq[n - 1] = EQ;
      for (int i = 0; i < n; i++) begin
        exp_lat = m_token(seq[i]);
        send(seq[i], lat);
        chk($sformatf("rand%0d tok%0d latency", s, i), 32'(lat), 32'(exp_lat));
      end
      chk($sformatf("rand%0d answer", s), calc_answer, m_ans);
      chk($sformatf("rand%0d error", s), 32'(error), 32'(m_err));
      chk($sformatf("rand%0d is_equal", s), 32'(is_equal), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
